// File: rtl/alu_share_arbiter.sv
// Sequences one external combinational ALU between two requesters, round-robin, IDLE->EXEC->RESP.
// Define ALU_ARB_CNT_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic [OP_W-1:0]   req0_card,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    input  logic [OP_W-1:0]   req1_card,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [OP_W-1:0]   alu_card,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_cout,
    input  logic              alu_zero,
`ifdef ALU_ARB_CNT_EN
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_f,
    output logic              rsp_cout,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   grant;
    logic   req_hs;
    logic   rsp_hs;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // Contention resolved by the pointer; a lone requester always wins.
        if (req0_valid && req1_valid) grant = ptr;
        else                          grant = req1_valid;
        case (state)
            IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_nxt  = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_hs = req0_ready | req1_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_card  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_f     <= '0;
            rsp_cout  <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            if (req_hs) begin
                alu_a    <= grant ? req1_a    : req0_a;
                alu_b    <= grant ? req1_b    : req0_b;
                alu_cin  <= grant ? req1_cin  : req0_cin;
                alu_card <= grant ? req1_card : req0_card;
                rsp_id   <= grant;
            end
            // ALU outputs have had the whole EXEC cycle to settle.
            if (state == EXEC) begin
                rsp_f     <= alu_f;
                rsp_cout  <= alu_cout;
                rsp_zero  <= alu_zero;
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
                ptr       <= ~rsp_id;
            end
        end
    end

`ifdef ALU_ARB_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && req0_valid) grant_cnt0 <= sat_inc(grant_cnt0);
            if (req1_ready && req1_valid) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, table-driven vectors, scoreboard and corner-case sequences.
module tb_alu_share_arbiter;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_cin;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [OP_W-1:0]   req0_card;
    logic              req1_valid, req1_ready, req1_cin;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [OP_W-1:0]   req1_card;
    logic [DATA_W-1:0] alu_a, alu_b, alu_f;
    logic              alu_cin, alu_cout, alu_zero;
    logic [OP_W-1:0]   alu_card;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
    logic [DATA_W-1:0] rsp_f;
`ifdef ALU_ARB_CNT_EN
    logic [15:0]       grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_card(req0_card),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_card(req1_card),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_card(alu_card),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_zero(alu_zero),
`ifdef ALU_ARB_CNT_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
    );

    // Behavioural ALU: 1 = A+B, 2 = A+B+Cin, 3 = A^B, otherwise A&B.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic [4:0] card);
        case (card)
            5'd1:    return {1'b0, a} + {1'b0, b};
            5'd2:    return {1'b0, a} + {1'b0, b} + {32'b0, cin};
            5'd3:    return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    assign {alu_cout, alu_f} = alu_fn(alu_a, alu_b, alu_cin, alu_card);
    assign alu_zero = (alu_f == '0);

    typedef struct packed {
        logic        id;
        logic [31:0] f;
        logic        cout;
        logic        zero;
    } exp_t;

    typedef struct packed {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [4:0]  card;
        logic [31:0] f;
        logic        cout;
        logic        zero;
    } vec_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt0   = 0;
    int   cnt1   = 0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic exp_t mk_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic [4:0] card);
        exp_t e;
        logic [32:0] r;
        r      = alu_fn(a, b, cin, card);
        e.id   = id;
        e.f    = r[31:0];
        e.cout = r[32];
        e.zero = (r[31:0] == 32'h0);
        return e;
    endfunction

    // Monitor: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            cnt0 = 0;
            cnt1 = 0;
        end else begin
            if (req0_valid && req1_valid)
                check("ready_excl", {31'b0, req0_ready & req1_ready}, 32'h0);
            if (req0_valid && req0_ready) begin
                sb_q.push_back(mk_exp(1'b0, req0_a, req0_b, req0_cin, req0_card));
                grant_log.push_back(0);
                cnt0++;
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back(mk_exp(1'b1, req1_a, req1_b, req1_cin, req1_card));
                grant_log.push_back(1);
                cnt1++;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_id}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_id", {31'b0, rsp_id}, {31'b0, e.id});
                    check("sb_f", rsp_f, e.f);
                    check("sb_cout", {31'b0, rsp_cout}, {31'b0, e.cout});
                    check("sb_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [4:0] card);
        bit got = 0;
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_card = card; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_card = card; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("issue");
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !rsp_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0017, 32'h0000_033F, 1'b1, 5'd1, 32'h0000_0356, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5'd2, 32'h0000_0000, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd1, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 5'd2, 32'h2345_678A, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 5'd3, 32'h5A5A_A5A5, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 5'd3, 32'h0000_0000, 1'b0, 1'b1};

        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0; req0_card = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0; req1_card = 0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_alu_misc", {26'b0, alu_cin, alu_card}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_f", rsp_f, 32'h0);
        check("rst_rsp_misc", {29'b0, rsp_id, rsp_cout, rsp_zero}, 32'h0);
        check("rst_ready", {30'b0, req0_ready, req1_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors: latency, operand registers and results.
        for (int k = 0; k < 6; k++) begin
            issue(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].card);
            check("vec_alu_a", alu_a, vecs[k].a);
            check("vec_alu_b", alu_b, vecs[k].b);
            @(negedge clk);
            check("vec_lat_exec", {31'b0, rsp_valid}, 32'h0);
            @(negedge clk);
            check("vec_lat_resp", {31'b0, rsp_valid}, 32'h1);
            check("vec_id", {31'b0, rsp_id}, {31'b0, vecs[k].id});
            check("vec_f", rsp_f, vecs[k].f);
            check("vec_cout", {31'b0, rsp_cout}, {31'b0, vecs[k].cout});
            check("vec_zero", {31'b0, rsp_zero}, {31'b0, vecs[k].zero});
            @(posedge clk);
            #1;
        end
        check("hold_after_hs", rsp_f, vecs[5].f);

        // Contention from reset: grant order must alternate starting at requester 0.
        do_reset();
        grant_log.delete();
        req0_a = 32'd5;         req0_b = 32'd7; req0_cin = 0; req0_card = 5'd1;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_cin = 0; req1_card = 5'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (grant_log.size() < 4) fail_now("contention");
        else for (int i = 0; i < 4; i++) check("grant_order", grant_log[i], i % 2);
        drain();

        // Backpressure with a second request waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0100, 32'h0000_0023, 1'b0, 5'd1);
        req0_a = 32'd1; req0_b = 32'd2; req0_cin = 0; req0_card = 5'd1;
        req0_valid = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) fail_now("bp_rsp");
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", {31'b0, rsp_valid}, 32'h1);
            check("bp_f", rsp_f, 32'h0000_0123);
            check("bp_ready0", {31'b0, req0_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_hs", {31'b0, req0_ready}, 32'h0);
        @(negedge clk);
        check("bp_accept_next", {31'b0, req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        drain();

        // Reset during EXEC: pointer was left at 1 by the last requester-0 response.
        issue(1'b0, 32'd9, 32'd9, 1'b0, 5'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("mid_rst_alu_a", alu_a, 32'h0);
        check("mid_rst_alu_b", alu_b, 32'h0);
        check("mid_rst_alu_misc", {26'b0, alu_cin, alu_card}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_ghost_rsp", {31'b0, rsp_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        req0_a = 32'd3; req0_b = 32'd4; req0_card = 5'd1;
        req1_a = 32'd6; req1_b = 32'd8; req1_card = 5'd3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("ptr_after_rst", {30'b0, req0_ready, req1_ready}, 32'h2);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

`ifdef ALU_ARB_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, i, 32'd1, 1'b0, 5'd1);
            drain();
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, i, 32'd2, 1'b0, 5'd1);
            drain();
        end
        @(negedge clk);
        check("grant_cnt0", {16'b0, grant_cnt0}, 32'd3);
        check("grant_cnt1", {16'b0, grant_cnt1}, 32'd2);
        check("grant_cnt0_model", {16'b0, grant_cnt0}, cnt0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
